opb_register_simulink2ppc_latched: RTL and testbench

OPB slave register carrying data in the fabric-to-processor direction. User logic presents a 32-bit word with a valid strobe; the block latches it and exposes it to software over the OPB at C_BASEADDR. A status word reports a new-data flag and a saturating overrun count. A software read of the data word clears the flag; any software write to the status word clears both the flag and the count. Single clock domain: user logic runs on OPB_Clk.

---
 rtl/opb_register_simulink2ppc_latched.sv | 121 ++++++++++++
 tb/tb_opb_register_simulink2ppc_latched.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/opb_register_simulink2ppc_latched.sv
// Fabric-to-PPC OPB register: latches a user word, exposes DATA/STATUS words, one-cycle ack.
// Ack one cycle after select; no back-pressure to fabric beyond the user_new_pending flag.
module opb_register_simulink2ppc_latched #(
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter logic [31:0] C_BASEADDR   = 32'h01010300,
  parameter logic [31:0] C_HIGHADDR   = 32'h010103FF,
  parameter              C_FAMILY     = "virtex6"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic                      Sl_xferAck,
  input  logic [31:0]               user_data_in,
  input  logic                      user_data_valid,
  output logic                      user_new_pending
);

  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

  state_t            state_q, state_d;
  logic [31:0]       data_q, data_d;
  logic              new_data_q, new_data_d;
  logic [7:0]        ovr_cnt_q, ovr_cnt_d;
  logic [31:0]       rd_dat_q, rd_dat_d;
  logic              rnw_q, rnw_d;
  logic              wsel_q, wsel_d;

  logic              hit;
  logic              addr_wsel;
  logic [31:0]       status_word;
  logic              data_rd_clr;
  logic              status_wr_clr;
  logic              unused_ok;

  // Byte enables, write data, seqAddr and family carry no function here.
  assign unused_ok = ^{OPB_BE, OPB_DBus, OPB_seqAddr, (C_FAMILY == "virtex6")};

  assign hit         = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign addr_wsel   = OPB_ABus[C_OPB_AWIDTH-3];
  assign status_word = {16'h0000, ovr_cnt_q, 7'b0000000, new_data_q};

  // Software side effects apply on the edge leaving ACK, using the latched access type.
  assign data_rd_clr   = (state_q == ACK) &&  rnw_q && !wsel_q;
  assign status_wr_clr = (state_q == ACK) && !rnw_q &&  wsel_q;

  always_comb begin
    state_d  = state_q;
    rd_dat_d = 32'h0;
    rnw_d    = rnw_q;
    wsel_d   = wsel_q;
    case (state_q)
      IDLE: begin
        if (hit) begin
          state_d = ACK;
          rnw_d   = OPB_RNW;
          wsel_d  = addr_wsel;
          if (OPB_RNW) rd_dat_d = addr_wsel ? status_word : data_q;
        end
      end
      ACK:     state_d = HOLD;
      HOLD:    if (!OPB_select) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A fabric capture on the same edge as a software clear wins for new_data.
  always_comb begin
    data_d     = data_q;
    new_data_d = new_data_q;
    ovr_cnt_d  = ovr_cnt_q;
    if (data_rd_clr || status_wr_clr) new_data_d = 1'b0;
    if (status_wr_clr) begin
      ovr_cnt_d = 8'h00;
    end else if (user_data_valid && new_data_q && !data_rd_clr && (ovr_cnt_q != 8'hFF)) begin
      ovr_cnt_d = ovr_cnt_q + 8'd1;
    end
    if (user_data_valid) begin
      data_d     = user_data_in;
      new_data_d = 1'b1;
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      state_q    <= IDLE;
      data_q     <= 32'h0;
      new_data_q <= 1'b0;
      ovr_cnt_q  <= 8'h00;
      rd_dat_q   <= 32'h0;
      rnw_q      <= 1'b0;
      wsel_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      new_data_q <= new_data_d;
      ovr_cnt_q  <= ovr_cnt_d;
      rd_dat_q   <= rd_dat_d;
      rnw_q      <= rnw_d;
      wsel_q     <= wsel_d;
    end
  end

  // rd_dat_q is only loaded on the IDLE->ACK edge, so it is zero outside the ACK cycle.
  assign Sl_DBus          = rd_dat_q;
  assign Sl_xferAck       = (state_q == ACK);
  assign Sl_errAck        = 1'b0;
  assign Sl_retry         = 1'b0;
  assign Sl_toutSup       = 1'b0;
  assign user_new_pending = new_data_q;

endmodule

// File: tb/tb_opb_register_simulink2ppc_latched.sv
// Directed bench for the fabric-to-PPC latched OPB register.
module tb_opb_register_simulink2ppc_latched;

  logic        clk;
  logic        rst_n;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] dbus_in;
  logic        rnw;
  logic        sel;
  logic        seq_addr;
  logic [0:31] dbus_out;
  logic        err_ack;
  logic        retry;
  logic        tout_sup;
  logic        xfer_ack;
  logic [31:0] udata;
  logic        uvld;
  logic        upend;

  int errors = 0;
  int checks = 0;
  int nack;

  localparam logic [31:0] A_DATA = 32'h01010300;
  localparam logic [31:0] A_STAT = 32'h01010304;

  opb_register_simulink2ppc_latched dut (
    .OPB_Clk          (clk),
    .OPB_Rst_n        (rst_n),
    .OPB_ABus         (abus),
    .OPB_BE           (be),
    .OPB_DBus         (dbus_in),
    .OPB_RNW          (rnw),
    .OPB_select       (sel),
    .OPB_seqAddr      (seq_addr),
    .Sl_DBus          (dbus_out),
    .Sl_errAck        (err_ack),
    .Sl_retry         (retry),
    .Sl_toutSup       (tout_sup),
    .Sl_xferAck       (xfer_ack),
    .user_data_in     (udata),
    .user_data_valid  (uvld),
    .user_new_pending (upend)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [31:0] d);
    uvld  = 1'b1;
    udata = d;
    @(posedge clk); #1;
    uvld  = 1'b0;
  endtask

  // One OPB access; optionally fires a user capture on the edge that leaves ACK.
  task automatic opb_access(input string tag, input logic [31:0] addr, input logic is_rd,
                            input logic [31:0] wdat, input logic [31:0] exp_rd,
                            input logic collide, input logic [31:0] cdat);
    sel     = 1'b1;
    abus    = addr;
    rnw     = is_rd;
    dbus_in = wdat;
    @(posedge clk); #1;
    check({tag, "_ack"}, {31'h0, xfer_ack}, 32'h1);
    check({tag, "_dat"}, dbus_out, is_rd ? exp_rd : 32'h0);
    sel     = 1'b0;
    abus    = '0;
    rnw     = 1'b0;
    dbus_in = '0;
    if (collide) begin
      uvld  = 1'b1;
      udata = cdat;
    end
    @(posedge clk); #1;
    uvld = 1'b0;
    check({tag, "_ack_off"}, {31'h0, xfer_ack}, 32'h0);
    check({tag, "_dat_off"}, dbus_out, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; abus = '0; be = 4'hF; dbus_in = '0; rnw = 1'b0;
    sel = 1'b0; seq_addr = 1'b0; udata = '0; uvld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'h0, xfer_ack}, 32'h0);
    check("rst_dbus", dbus_out, 32'h0);
    check("rst_pend", {31'h0, upend}, 32'h0);
    check("rst_ties", {29'h0, err_ack, retry, tout_sup}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    opb_access("rd_data_rst", A_DATA, 1'b1, 32'h0, 32'h00000000, 1'b0, 32'h0);
    opb_access("rd_stat_rst", A_STAT, 1'b1, 32'h0, 32'h00000000, 1'b0, 32'h0);

    pulse(32'hDEADBEEF);
    check("pend_set", {31'h0, upend}, 32'h1);
    opb_access("rd_stat_new", A_STAT, 1'b1, 32'h0, 32'h00000001, 1'b0, 32'h0);
    opb_access("rd_data_dead", A_DATA, 1'b1, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0);
    check("pend_clr", {31'h0, upend}, 32'h0);
    opb_access("rd_stat_clr", A_STAT, 1'b1, 32'h0, 32'h00000000, 1'b0, 32'h0);

    pulse(32'h1); pulse(32'h2); pulse(32'h3);
    opb_access("rd_stat_ovr2", A_STAT, 1'b1, 32'h0, 32'h00000201, 1'b0, 32'h0);
    opb_access("rd_data_3", A_DATA, 1'b1, 32'h0, 32'h00000003, 1'b0, 32'h0);
    opb_access("rd_stat_ovr2b", A_STAT, 1'b1, 32'h0, 32'h00000200, 1'b0, 32'h0);
    opb_access("wr_stat", A_STAT, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    opb_access("rd_stat_wclr", A_STAT, 1'b1, 32'h0, 32'h00000000, 1'b0, 32'h0);
    opb_access("wr_data_ign", A_DATA, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0, 32'h0);
    opb_access("rd_data_keep", A_DATA, 1'b1, 32'h0, 32'h00000003, 1'b0, 32'h0);

    for (int i = 0; i < 300; i++) pulse(32'(i));
    opb_access("rd_stat_sat", A_STAT, 1'b1, 32'h0, 32'h0000FF01, 1'b0, 32'h0);
    opb_access("wr_stat_sat", A_STAT, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h0);
    opb_access("rd_stat_sclr", A_STAT, 1'b1, 32'h0, 32'h00000000, 1'b0, 32'h0);
    opb_access("rd_data_299", A_DATA, 1'b1, 32'h0, 32'h0000012B, 1'b0, 32'h0);

    pulse(32'h11111111);
    opb_access("rd_data_coll", A_DATA, 1'b1, 32'h0, 32'h11111111, 1'b1, 32'hAAAA5555);
    check("coll_pend", {31'h0, upend}, 32'h1);
    opb_access("rd_stat_coll", A_STAT, 1'b1, 32'h0, 32'h00000001, 1'b0, 32'h0);
    opb_access("rd_data_aaaa", A_DATA, 1'b1, 32'h0, 32'hAAAA5555, 1'b0, 32'h0);

    pulse(32'hB1); pulse(32'hB2);
    opb_access("rd_stat_pre", A_STAT, 1'b1, 32'h0, 32'h00000101, 1'b0, 32'h0);
    opb_access("wr_stat_coll", A_STAT, 1'b0, 32'h0, 32'h0, 1'b1, 32'hB3);
    opb_access("rd_stat_wcoll", A_STAT, 1'b1, 32'h0, 32'h00000001, 1'b0, 32'h0);
    opb_access("rd_data_b3", A_DATA, 1'b1, 32'h0, 32'h000000B3, 1'b0, 32'h0);

    sel = 1'b1; abus = 32'h01010400; rnw = 1'b1;
    nack = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (xfer_ack) nack++;
      check("oor_dbus", dbus_out, 32'h0);
    end
    check("oor_acks", 32'(nack), 32'h0);
    sel = 1'b0; abus = '0;
    @(posedge clk); #1;

    pulse(32'h00C0FFEE);
    sel = 1'b1; abus = A_DATA; rnw = 1'b1;
    nack = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 0) check("hold_first_ack", {31'h0, xfer_ack}, 32'h1);
      if (xfer_ack) nack++;
    end
    check("hold_acks", 32'(nack), 32'h1);
    sel = 1'b0; abus = '0;
    @(posedge clk); #1;

    pulse(32'h00000055);
    sel = 1'b1; abus = A_DATA; rnw = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ack", {31'h0, xfer_ack}, 32'h1);
    check("rst_mid_dat", dbus_out, 32'h00000055);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_abort_ack", {31'h0, xfer_ack}, 32'h0);
    check("rst_abort_dbus", dbus_out, 32'h0);
    check("rst_abort_pend", {31'h0, upend}, 32'h0);
    sel = 1'b0; abus = '0; rst_n = 1'b1;
    @(posedge clk); #1;
    opb_access("rd_stat_post", A_STAT, 1'b1, 32'h0, 32'h00000000, 1'b0, 32'h0);
    opb_access("rd_data_post", A_DATA, 1'b1, 32'h0, 32'h00000000, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
